// File: rtl/edge_pulse_pkg.sv
// Shared types and helpers for the edge pulse bank: the per-channel edge
// select encoding and the counter width helper used by every channel.
package edge_pulse_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_e;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    if (max_val < 1) begin
      w = 1;
    end else begin
      w = $clog2(max_val + 1);
    end
    return w;
  endfunction

  // True when an accepted transition to level 'rise' qualifies under mode m.
  function automatic logic mode_allows(input edge_mode_e m, input logic rise);
    logic ok;
    case (m)
      EDGE_NONE: ok = 1'b0;
      EDGE_RISE: ok = rise;
      EDGE_FALL: ok = ~rise;
      EDGE_BOTH: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/edge_pulse_bank_if.sv
// Bundle of the channel-vector signals between the raw-input side (master)
// and the edge pulse bank (slave).
interface edge_pulse_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   in;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   clr;
  logic [CHANNELS-1:0]   out;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   sticky;
  logic                  any_out;

  modport master (
    output in, mode, clr,
    input  out, level, sticky, any_out
  );

  modport slave (
    input  in, mode, clr,
    output out, level, sticky, any_out
  );
endinterface

// File: rtl/edge_pulse_chan.sv
// One channel: optional synchroniser, debounce filter, edge qualification,
// retriggerable pulse stretcher and a sticky event flag.
module edge_pulse_chan
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int PULSE_W     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  edge_mode_e mode,
  input  logic       clr,
  output logic       out,
  output logic       level,
  output logic       sticky
);

  localparam int DCW = cnt_width(DEBOUNCE);
  localparam int PCW = cnt_width(PULSE_W);
  localparam logic [DCW-1:0] DCNT_MAX = DCW'(DEBOUNCE - 1);
  localparam logic [PCW-1:0] PCNT_LOAD = PCW'(PULSE_W);

  logic           s_s;
  logic           filt_q, filt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           sticky_q, sticky_d;
  logic           out_q, out_d;
  logic           trans_s;
  logic           event_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_s = in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      // Shift the raw input one stage deeper into the synchroniser chain.
      always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = in;
      end

      // Synchroniser flops; cleared on reset so a held-high input re-rises.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign s_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Debounce: accept a new level only after DEBOUNCE consecutive disagreeing samples.
  always_comb begin
    filt_d  = filt_q;
    dcnt_d  = dcnt_q;
    trans_s = 1'b0;
    if (s_s == filt_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_MAX) begin
      filt_d  = ~filt_q;
      dcnt_d  = '0;
      trans_s = 1'b1;
    end else begin
      dcnt_d = dcnt_q + DCW'(1);
    end
  end

  assign event_s = trans_s & mode_allows(mode, filt_d);

  // Pulse stretcher and sticky flag; a new event reloads the full width.
  always_comb begin
    if (event_s) begin
      pcnt_d = PCNT_LOAD;
    end else if (pcnt_q != '0) begin
      pcnt_d = pcnt_q - PCW'(1);
    end else begin
      pcnt_d = pcnt_q;
    end

    if (event_s) begin
      sticky_d = 1'b1;
    end else if (clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end

    out_d = (pcnt_d != '0);
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q   <= 1'b0;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      sticky_q <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      dcnt_q   <= dcnt_d;
      pcnt_q   <= pcnt_d;
      sticky_q <= sticky_d;
      out_q    <= out_d;
    end
  end

  assign out    = out_q;
  assign level  = filt_q;
  assign sticky = sticky_q;

endmodule

// File: rtl/edge_pulse_bank.sv
// Bank of independent edge pulse channels with a combined pulse indicator.
module edge_pulse_bank
  import edge_pulse_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int PULSE_W     = 1
) (
  input logic               clk,
  input logic               reset,
  edge_pulse_bank_if.slave  bus
);

  logic [CHANNELS-1:0] out_s;
  logic [CHANNELS-1:0] level_s;
  logic [CHANNELS-1:0] sticky_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_pulse_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .PULSE_W     (PULSE_W)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .in     (bus.in[i]),
      .mode   (edge_mode_e'(bus.mode[2*i +: 2])),
      .clr    (bus.clr[i]),
      .out    (out_s[i]),
      .level  (level_s[i]),
      .sticky (sticky_s[i])
    );
  end

  assign bus.out     = out_s;
  assign bus.level   = level_s;
  assign bus.sticky  = sticky_s;
  assign bus.any_out = |out_s;

endmodule

// File: tb/tb_edge_pulse_bank.sv
// Directed bench for edge_pulse_bank: four instances with different
// parameter sets, a behavioural model checked every cycle, and literal
// expectations for latency, pulse width and flag behaviour.
module tb_edge_pulse_bank;

  localparam int NDUT = 4;
  localparam int NCH  = 4;

  logic clk;
  logic reset;

  logic [NCH-1:0]   in_v     [NDUT];
  logic [2*NCH-1:0] mode_v   [NDUT];
  logic [NCH-1:0]   clr_v    [NDUT];
  logic [NCH-1:0]   out_v    [NDUT];
  logic [NCH-1:0]   level_v  [NDUT];
  logic [NCH-1:0]   sticky_v [NDUT];
  logic             any_v    [NDUT];

  int sync_p  [NDUT] = '{2, 2, 0, 2};
  int deb_p   [NDUT] = '{4, 4, 1, 4};
  int pw_p    [NDUT] = '{1, 3, 5, 4};

  int checks = 0;
  int errors = 0;

  edge_pulse_bank_if #(.CHANNELS(NCH)) if0 ();
  edge_pulse_bank_if #(.CHANNELS(NCH)) if1 ();
  edge_pulse_bank_if #(.CHANNELS(NCH)) if2 ();
  edge_pulse_bank_if #(.CHANNELS(NCH)) if3 ();

  edge_pulse_bank #(.CHANNELS(NCH), .SYNC_STAGES(2), .DEBOUNCE(4), .PULSE_W(1))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  edge_pulse_bank #(.CHANNELS(NCH), .SYNC_STAGES(2), .DEBOUNCE(4), .PULSE_W(3))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  edge_pulse_bank #(.CHANNELS(NCH), .SYNC_STAGES(0), .DEBOUNCE(1), .PULSE_W(5))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));
  edge_pulse_bank #(.CHANNELS(NCH), .SYNC_STAGES(2), .DEBOUNCE(4), .PULSE_W(4))
    u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  assign if0.in = in_v[0];  assign if0.mode = mode_v[0];  assign if0.clr = clr_v[0];
  assign if1.in = in_v[1];  assign if1.mode = mode_v[1];  assign if1.clr = clr_v[1];
  assign if2.in = in_v[2];  assign if2.mode = mode_v[2];  assign if2.clr = clr_v[2];
  assign if3.in = in_v[3];  assign if3.mode = mode_v[3];  assign if3.clr = clr_v[3];

  assign out_v[0] = if0.out;  assign level_v[0] = if0.level;  assign sticky_v[0] = if0.sticky;  assign any_v[0] = if0.any_out;
  assign out_v[1] = if1.out;  assign level_v[1] = if1.level;  assign sticky_v[1] = if1.sticky;  assign any_v[1] = if1.any_out;
  assign out_v[2] = if2.out;  assign level_v[2] = if2.level;  assign sticky_v[2] = if2.sticky;  assign any_v[2] = if2.any_out;
  assign out_v[3] = if3.out;  assign level_v[3] = if3.level;  assign sticky_v[3] = if3.sticky;  assign any_v[3] = if3.any_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // in_hist[d][c][k] : input sampled k+1 edges ago
  // s_win[d][c][k]   : synchronised sample k edges ago, s_cnt valid entries since last acceptance
  bit in_hist [NDUT][NCH][8];
  bit s_win   [NDUT][NCH][8];
  int s_cnt   [NDUT][NCH];
  bit m_level [NDUT][NCH];
  bit m_stick [NDUT][NCH];
  int m_rem   [NDUT][NCH];
  bit started = 1'b0;

  bit         m_s, m_tr, m_ev, m_all;
  logic [1:0] m_md;

  always @(posedge clk) begin
    started = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < NCH; c++) begin
        if (reset) begin
          for (int k = 0; k < 8; k++) begin
            in_hist[d][c][k] = 1'b0;
            s_win[d][c][k]   = 1'b0;
          end
          s_cnt[d][c]   = 0;
          m_level[d][c] = 1'b0;
          m_stick[d][c] = 1'b0;
          m_rem[d][c]   = 0;
        end else begin
          // value seen by the debouncer at this edge: input delayed by the sync depth
          if (sync_p[d] == 0) m_s = in_v[d][c];
          else                m_s = in_hist[d][c][sync_p[d]-1];
          for (int k = 7; k > 0; k--) in_hist[d][c][k] = in_hist[d][c][k-1];
          in_hist[d][c][0] = in_v[d][c];

          for (int k = 7; k > 0; k--) s_win[d][c][k] = s_win[d][c][k-1];
          s_win[d][c][0] = m_s;
          if (s_cnt[d][c] < 8) s_cnt[d][c]++;

          // accept a new level once the last DEBOUNCE samples all disagree with it
          m_tr = 1'b0;
          if (s_cnt[d][c] >= deb_p[d]) begin
            m_all = 1'b1;
            for (int k = 0; k < deb_p[d]; k++)
              if (s_win[d][c][k] == m_level[d][c]) m_all = 1'b0;
            if (m_all) begin
              m_level[d][c] = ~m_level[d][c];
              s_cnt[d][c]   = 0;
              m_tr          = 1'b1;
            end
          end

          m_md = mode_v[d][2*c +: 2];
          m_ev = m_tr && ((m_md == 2'd3) ||
                          (m_md == 2'd1 && m_level[d][c]) ||
                          (m_md == 2'd2 && !m_level[d][c]));

          if (m_ev) m_rem[d][c] = pw_p[d];
          else if (m_rem[d][c] > 0) m_rem[d][c]--;

          if (m_ev) m_stick[d][c] = 1'b1;
          else if (clr_v[d][c]) m_stick[d][c] = 1'b0;
        end
      end
    end
  end

  logic [NCH-1:0] exp_o, exp_l, exp_s;

  // every-cycle comparison of all instances against the model
  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int c = 0; c < NCH; c++) begin
          exp_o[c] = (m_rem[d][c] != 0);
          exp_l[c] = m_level[d][c];
          exp_s[c] = m_stick[d][c];
        end
        checks += 4;
        if (out_v[d] !== exp_o) begin
          errors++;
          $display("FAIL model_out dut%0d t=%0t got %b exp %b", d, $time, out_v[d], exp_o);
        end
        if (level_v[d] !== exp_l) begin
          errors++;
          $display("FAIL model_level dut%0d t=%0t got %b exp %b", d, $time, level_v[d], exp_l);
        end
        if (sticky_v[d] !== exp_s) begin
          errors++;
          $display("FAIL model_sticky dut%0d t=%0t got %b exp %b", d, $time, sticky_v[d], exp_s);
        end
        if (any_v[d] !== (|exp_o)) begin
          errors++;
          $display("FAIL model_any dut%0d t=%0t got %b exp %b", d, $time, any_v[d], |exp_o);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // cycles from the current negedge until out[d][c] is first seen high
  task automatic wait_out(input int d, input int c, output int lat);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (out_v[d][c] === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // cycles out[d][c] stays high, counting the current (already high) cycle
  task automatic run_len(input int d, input int c, output int run);
    run = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_v[d][c] === 1'b1) run++;
      else break;
    end
  endtask

  // ---------------- stimulus ----------------
  int lat, run, hits;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      in_v[d]  = 4'b0000;
      clr_v[d] = 4'b0000;
    end
    mode_v[0] = 8'b00_01_11_01;  // ch0 RISE, ch1 BOTH, ch2 RISE, ch3 NONE
    mode_v[1] = 8'b00_00_00_10;  // ch0 FALL
    mode_v[2] = 8'b00_00_00_11;  // ch0 BOTH
    mode_v[3] = 8'b01_00_00_00;  // ch3 RISE
    step(3);
    chk("reset_out0", int'(out_v[0]), 0);
    chk("reset_level0", int'(level_v[0]), 0);
    chk("reset_sticky0", int'(sticky_v[0]), 0);
    reset = 1'b0;
    step(2);

    // rise on a RISE channel, pulse width 1, fall ignored
    in_v[0][0] = 1'b1;
    wait_out(0, 0, lat);
    chk("t1_latency", lat, 6);
    chk("t1_level_at_pulse", int'(level_v[0][0]), 1);
    chk("t1_sticky_at_pulse", int'(sticky_v[0][0]), 1);
    step(1);
    chk("t1_out_one_cycle", int'(out_v[0][0]), 0);
    chk("t1_level_held", int'(level_v[0][0]), 1);
    in_v[0][0] = 1'b0;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_v[0][0] === 1'b1) hits++;
    end
    chk("t1_no_fall_pulse", hits, 0);
    chk("t1_level_fell", int'(level_v[0][0]), 0);

    // three-cycle glitch shorter than the debounce window
    in_v[0][1] = 1'b1;
    step(3);
    in_v[0][1] = 1'b0;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_v[0][1] === 1'b1 || level_v[0][1] === 1'b1 || sticky_v[0][1] === 1'b1) hits++;
    end
    chk("t2_glitch_ignored", hits, 0);

    // FALL mode, width 3
    in_v[1][0] = 1'b1;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_v[1][0] === 1'b1) hits++;
    end
    chk("t3_no_rise_pulse", hits, 0);
    chk("t3_level_high", int'(level_v[1][0]), 1);
    in_v[1][0] = 1'b0;
    wait_out(1, 0, lat);
    chk("t3_fall_latency", lat, 6);
    run_len(1, 0, run);
    chk("t3_width", run, 3);

    // two transitions two cycles apart stretch into one 7-cycle pulse
    in_v[2][0] = 1'b1;
    @(negedge clk);
    chk("t4_first_latency", int'(out_v[2][0]), 1);
    @(negedge clk);
    in_v[2][0] = 1'b0;
    run_len(2, 0, run);
    chk("t4_merged_width", run + 1, 7);

    // clear coinciding with the event loses; a lone clear wins
    in_v[0][2] = 1'b1;
    step(5);
    clr_v[0][2] = 1'b1;
    @(negedge clk);
    chk("t5_set_beats_clr", int'(sticky_v[0][2]), 1);
    chk("t5_pulse", int'(out_v[0][2]), 1);
    @(negedge clk);
    chk("t5_clr_alone", int'(sticky_v[0][2]), 0);
    clr_v[0][2] = 1'b0;
    step(2);

    // reset in the middle of a width-4 pulse, input held high
    in_v[3][3] = 1'b1;
    wait_out(3, 3, lat);
    chk("t6_latency", lat, 6);
    @(negedge clk);
    chk("t6_mid_pulse", int'(out_v[3][3]), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_out_cleared", int'(out_v[3]), 0);
    chk("t6_level_cleared", int'(level_v[3]), 0);
    chk("t6_sticky_cleared", int'(sticky_v[3]), 0);
    chk("t6_any_cleared", int'(any_v[3]), 0);
    reset = 1'b0;
    wait_out(3, 3, lat);
    chk("t6_relatency", lat, 6);
    run_len(3, 3, run);
    chk("t6_width", run, 4);
    step(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
